// File: rtl/hack_pkg.sv
// Shared op encodings for the bitwise logic pipe.
// Imported by the ALU and benches.
package hack_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOTX = 3'd6;
  localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/hack_logic_op.sv
// Combinational bitwise op unit.
// Produces the result plus zero / negative flags.
module hack_logic_op
  import hack_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  op_t          op,
  output logic [N-1:0] out,
  output logic         zr,
  output logic         ng
);

  always_comb begin
    out = '0;
    case (op)
      OP_AND:  out = x & y;
      OP_OR:   out = x | y;
      OP_XOR:  out = x ^ y;
      OP_NAND: out = ~(x & y);
      OP_NOR:  out = ~(x | y);
      OP_XNOR: out = ~(x ^ y);
      OP_NOTX: out = ~x;
      OP_PASS: out = x;
      default: out = '0;
    endcase
  end

  assign zr = ~|out;
  assign ng = out[N-1];

endmodule

// File: rtl/hack_logic_pipe.sv
// Two-stage valid/ready pipe around hack_logic_op.
// S1 holds operands, S2 holds result and flags.
module hack_logic_pipe
  import hack_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  input  logic [2:0]    op,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out,
  output logic          zr,
  output logic          ng,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] ops_done
);

  logic          s1_v_q, s1_v_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  op_t           op_q, op_d;
  logic          s2_v_q, s2_v_d;
  logic [N-1:0]  out_q, out_d;
  logic          zr_q, zr_d;
  logic          ng_q, ng_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  alu_out;
  logic          alu_zr;
  logic          alu_ng;
  logic          s2_adv;
  logic          in_fire;
  logic          out_fire;

  hack_logic_op #(.N(N)) u_op (
    .x   (x_q),
    .y   (y_q),
    .op  (op_q),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign s2_adv   = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_v_q && out_ready;

  always_comb begin
    s1_v_d = s1_v_q;
    x_d    = x_q;
    y_d    = y_q;
    op_d   = op_q;
    s2_v_d = s2_v_q;
    out_d  = out_q;
    zr_d   = zr_q;
    ng_d   = ng_q;
    cnt_d  = cnt_q;
    if (in_ready) begin
      s1_v_d = in_valid;
    end
    if (in_fire) begin
      x_d  = x;
      y_d  = y;
      op_d = op;
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
    end
    // result regs only load on a real move so a stalled output holds
    if (s2_adv && s1_v_q) begin
      out_d = alu_out;
      zr_d  = alu_zr;
      ng_d  = alu_ng;
    end
    if (out_fire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      op_q   <= OP_AND;
      s2_v_q <= 1'b0;
      out_q  <= '0;
      zr_q   <= 1'b0;
      ng_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      x_q    <= x_d;
      y_q    <= y_d;
      op_q   <= op_d;
      s2_v_q <= s2_v_d;
      out_q  <= out_d;
      zr_q   <= zr_d;
      ng_q   <= ng_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign out_valid = s2_v_q;
  assign ops_done  = cnt_q;

endmodule

// File: doc/hack_logic_pipe.md
HACK_LOGIC_PIPE -- requirements
Module: hack_logic_pipe

Interface
REQ-001 SHALL have parameter N, default 16, giving the operand and result width in bits (N >= 2).
REQ-002 SHALL have parameter CW, default 16, giving the completed-operation counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port x, input, N, operand X.
REQ-006 SHALL have port y, input, N, operand Y.
REQ-007 SHALL have port op, input, 3, operation select.
REQ-008 SHALL have port in_valid, input, 1, meaning x/y/op are valid.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts input this cycle.
REQ-010 SHALL have port out, output, N, the result.
REQ-011 SHALL have port zr, output, 1, set when out is all zeros.
REQ-012 SHALL have port ng, output, 1, equal to out[N-1].
REQ-013 SHALL have port out_valid, output, 1, meaning out/zr/ng are valid.
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-015 SHALL have port ops_done, output, CW, counting output handshakes.

Function
REQ-016 SHALL decode op as 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT x, 7 pass x; all operations are bitwise over N bits.
REQ-017 SHALL accept an input transfer when in_valid and in_ready are both 1 in the same cycle, and an output transfer when out_valid and out_ready are both 1.
REQ-018 SHALL implement two stages: S1 registers x, y and op; S2 registers the result, zr and ng; each stage has its own valid bit.
REQ-019 SHALL present a result accepted at edge k with out_valid=1 after edge k+1 (latency 2 edges) when no backpressure occurs.
REQ-020 SHALL sustain one transfer per cycle while out_ready stays 1.
REQ-021 SHALL advance S2 when S2 is empty or out_ready=1; S1 advances into S2 under the same condition.
REQ-022 SHALL drive in_ready = !S1.valid || S2 advances (combinational from out_ready; no combinational path from in_valid).
REQ-023 SHALL hold out, zr, ng and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL never drop or duplicate a transfer; with both stages full and out_ready=0, in_ready SHALL be 0.
REQ-025 SHALL increment ops_done by 1 on each output transfer, wrapping from 2^CW-1 to 0.
REQ-026 SHALL make simultaneous input and output transfers in one cycle both take effect, with occupancy unchanged.
REQ-027 SHALL have no effect on state from x, y, op or out_ready while the corresponding handshake is not active.

Reset
REQ-028 SHALL, while reset=1 at a rising edge, clear both valid bits, out, zr, ng and ops_done to 0; out_valid SHALL read 0 in the following cycle.
REQ-029 SHALL discard in-flight data when reset is asserted mid-operation; no output transfer SHALL occur in a cycle where reset=1.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-031 SHALL place the op encodings (3-bit constants) in shared package hack_pkg for reuse by the ALU and testbenches.
REQ-032 SHALL implement the bitwise operation and flag generation as one combinational sub-module, hack_logic_op (ports x, y, op, out, zr, ng; parameter N).
REQ-033 SHALL contain no latches, and only clk-edge registers.

Verification
REQ-034 SHALL verify the op sweep: N=16, x=16'h00F0, y=16'h0FF0, ops 0..7 back-to-back with out_ready=1 -> results 00F0, 0FF0, 0F00, FF0F, F00F, F0FF, FF0F, 00F0 in order, each 2 edges after acceptance, one per cycle.
REQ-035 SHALL verify flags: AND x=16'h1234, y=0 -> out=0, zr=1, ng=0; NOT x=16'h1234 -> out=EDCB, zr=0, ng=1.
REQ-036 SHALL verify backpressure: three inputs issued with out_ready=0 -> in_ready falls after two are accepted, out holds the first result stable; raising out_ready drains all three in order with no loss.
REQ-037 SHALL verify mid-operation reset: reset=1 for one cycle with both stages full -> out_valid=0, ops_done=0 next cycle, in_ready=1 after release, no stale result emitted.
REQ-038 SHALL verify counter wrap: CW=4, 17 transfers -> ops_done reads 1.
REQ-039 SHALL verify random throughput: 1000 random x/y/op with random in_valid/out_ready -> output sequence matches a reference model and ops_done equals the transfer count mod 2^CW.
